// File: rtl/pwm_pkg.sv
// Purpose: shared FSM encoding and default widths for the PWM compare/dead-time stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

  localparam int COUNTER_BITS_DEF  = 7;
  localparam int DEADTIME_BITS_DEF = 4;

  // Drive-stage state. Only HI_ON and LO_ON drive a gate; every other
  // state holds both sides off.
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_LO_ON    = 3'd1,
    ST_DT_TO_HI = 3'd2,
    ST_HI_ON    = 3'd3,
    ST_DT_TO_LO = 3'd4
  } pwm_state_t;

endpackage

// File: rtl/deadtime_fsm.sv
// Purpose: turns the raw PWM level into complementary high/low gate drives with dead time.
// Latency: state follows pwm_raw one clk later; a drive turns on deadtime_in clks after that.
// Backpressure: none; out_en low forces both drives off at the next edge.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   pwm_raw        registered compare result from the top
//   out_en         output enable, highest-priority transition to OFF
//   deadtime_in    dead-time length in clks, sampled when a dead-time interval begins
//   pwm_hi, pwm_lo Moore-decoded gate drives, never both high
module deadtime_fsm
  import pwm_pkg::*;
#(
  parameter int DEADTIME_BITS = DEADTIME_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pwm_raw,
  input  logic                     out_en,
  input  logic [DEADTIME_BITS-1:0] deadtime_in,
  output logic                     pwm_hi,
  output logic                     pwm_lo
);

  localparam logic [DEADTIME_BITS-1:0] DT_ONE = 1;

  pwm_state_t               state;
  pwm_state_t               state_nxt;
  logic [DEADTIME_BITS-1:0] dt_cnt;
  logic [DEADTIME_BITS-1:0] dt_cnt_nxt;
  logic [DEADTIME_BITS-1:0] dt_load;
  logic                     dt_zero_req;

  // The counter holds "cycles remaining minus one", so the dead-time state
  // lasts exactly deadtime_in cycles. A zero setting clamps to one cycle,
  // which only happens when leaving OFF.
  assign dt_zero_req = (deadtime_in == '0);
  assign dt_load     = dt_zero_req ? '0 : (deadtime_in - DT_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_OFF;
      dt_cnt <= '0;
    end else begin
      state  <= state_nxt;
      dt_cnt <= dt_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    dt_cnt_nxt = dt_cnt;
    if (!out_en) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          // Always pass through a dead-time state before the first drive.
          state_nxt  = pwm_raw ? ST_DT_TO_HI : ST_DT_TO_LO;
          dt_cnt_nxt = dt_load;
        end
        ST_LO_ON: begin
          if (pwm_raw) begin
            if (dt_zero_req) begin
              state_nxt = ST_HI_ON;
            end else begin
              state_nxt  = ST_DT_TO_HI;
              dt_cnt_nxt = dt_load;
            end
          end
        end
        ST_DT_TO_HI: begin
          // Raw level fell back before dead time ended: return to the low
          // side rather than emit a runt high pulse.
          if (!pwm_raw) begin
            state_nxt = ST_LO_ON;
          end else if (dt_cnt == '0) begin
            state_nxt = ST_HI_ON;
          end else begin
            dt_cnt_nxt = dt_cnt - DT_ONE;
          end
        end
        ST_HI_ON: begin
          if (!pwm_raw) begin
            if (dt_zero_req) begin
              state_nxt = ST_LO_ON;
            end else begin
              state_nxt  = ST_DT_TO_LO;
              dt_cnt_nxt = dt_load;
            end
          end
        end
        ST_DT_TO_LO: begin
          if (pwm_raw) begin
            state_nxt = ST_HI_ON;
          end else if (dt_cnt == '0) begin
            state_nxt = ST_LO_ON;
          end else begin
            dt_cnt_nxt = dt_cnt - DT_ONE;
          end
        end
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  // Decoded only from registered state, so the two drives are mutually
  // exclusive by construction.
  always_comb begin
    pwm_hi = (state == ST_HI_ON);
    pwm_lo = (state == ST_LO_ON);
  end

endmodule

// File: rtl/pwm_compare_deadtime.sv
// Purpose: counter-vs-duty compare with a period-aligned shadow duty register, feeding dead-time drive.
// Latency: pwm_raw/period_start 1 clk after counter_in; drives follow per deadtime_fsm.
// Backpressure: none; a stalled counter (count_en low) freezes period events, compare keeps tracking.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   counter_in, count_en  upstream up-counter value and its advance enable
//   duty_in, duty_wr      requested duty (>= 2^COUNTER_BITS is 100%) and its write strobe
//   deadtime_in, out_en   dead-time length and output enable for the drive stage
//   pwm_raw, period_start registered compare result and count-0 pulse
//   pwm_hi, pwm_lo        complementary gate drives
//   duty_pending          a written duty is waiting for the next period boundary
module pwm_compare_deadtime
  import pwm_pkg::*;
#(
  parameter int COUNTER_BITS  = COUNTER_BITS_DEF,
  parameter int DEADTIME_BITS = DEADTIME_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COUNTER_BITS-1:0]  counter_in,
  input  logic                     count_en,
  input  logic [COUNTER_BITS:0]    duty_in,
  input  logic                     duty_wr,
  input  logic [DEADTIME_BITS-1:0] deadtime_in,
  input  logic                     out_en,
  output logic                     pwm_raw,
  output logic                     pwm_hi,
  output logic                     pwm_lo,
  output logic                     period_start,
  output logic                     duty_pending
);

  logic [COUNTER_BITS:0] duty_active;
  logic [COUNTER_BITS:0] duty_pend_reg;
  logic                  period_wrap;
  logic                  transfer;
  logic                  cmp_lt;

  // The edge that moves the counter from its max value to 0 is the only
  // point where the active duty may change, so the new duty governs a
  // whole period starting at count 0.
  assign period_wrap = count_en && (counter_in == {COUNTER_BITS{1'b1}});
  assign transfer    = period_wrap && duty_pending;

  // The MSB of the duty alone marks the 100% case; below that the low bits
  // are compared directly against the counter.
  assign cmp_lt = duty_active[COUNTER_BITS] ||
                  (counter_in < duty_active[COUNTER_BITS-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_active   <= '0;
      duty_pend_reg <= '0;
      duty_pending  <= 1'b0;
      pwm_raw       <= 1'b0;
      period_start  <= 1'b0;
    end else begin
      if (duty_wr) begin
        duty_pend_reg <= duty_in;
      end
      // On a coincident write the old pending value moves to active while
      // the new value is captured, so pending stays set.
      if (transfer) begin
        duty_active <= duty_pend_reg;
      end
      if (duty_wr) begin
        duty_pending <= 1'b1;
      end else if (transfer) begin
        duty_pending <= 1'b0;
      end
      pwm_raw      <= cmp_lt;
      period_start <= count_en && (counter_in == '0);
    end
  end

  deadtime_fsm #(
    .DEADTIME_BITS (DEADTIME_BITS)
  ) u_deadtime_fsm (
    .clk         (clk),
    .reset       (reset),
    .pwm_raw     (pwm_raw),
    .out_en      (out_en),
    .deadtime_in (deadtime_in),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo)
  );

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
module tb_pwm_compare_deadtime;

  logic       clk;
  logic       reset;
  logic [6:0] counter_in;
  logic       count_en;
  logic [7:0] duty_in;
  logic       duty_wr;
  logic [3:0] deadtime_in;
  logic       out_en;
  logic       pwm_raw;
  logic       pwm_hi;
  logic       pwm_lo;
  logic       period_start;
  logic       duty_pending;

  pwm_compare_deadtime #(
    .COUNTER_BITS  (7),
    .DEADTIME_BITS (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .counter_in   (counter_in),
    .count_en     (count_en),
    .duty_in      (duty_in),
    .duty_wr      (duty_wr),
    .deadtime_in  (deadtime_in),
    .out_en       (out_en),
    .pwm_raw      (pwm_raw),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .period_start (period_start),
    .duty_pending (duty_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] duty;
    logic [3:0] dt;
    int         exp_raw;
    int         exp_hi;
    int         exp_lo;
  } vec_t;

  vec_t       vecs[10];
  int         n_tests;
  int         n_fail;
  int         ov_total;
  logic [6:0] cnt;

  // Advance one clock; the upstream counter model steps at the same edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) cnt = '0;
    else if (count_en) cnt = cnt + 7'd1;
    counter_in = cnt;
    if (pwm_hi === 1'b1 && pwm_lo === 1'b1) ov_total++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (int'(counter_in) != target && n < 300) begin
      tick();
      n++;
    end
    check("run_to", int'(counter_in), target);
  endtask

  task automatic wait_pend_clear();
    int n = 0;
    while (duty_pending && n < 400) begin
      tick();
      n++;
    end
    check("pend_clear", int'(duty_pending), 0);
  endtask

  task automatic write_duty(input logic [7:0] d);
    duty_in = d;
    duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
  endtask

  // One full period of samples, counting how long each output is high.
  task automatic measure(output int raw_c, output int hi_c, output int lo_c,
                         output int ps_c, output int ov_c);
    raw_c = 0; hi_c = 0; lo_c = 0; ps_c = 0; ov_c = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      raw_c += int'(pwm_raw);
      hi_c  += int'(pwm_hi);
      lo_c  += int'(pwm_lo);
      ps_c  += int'(period_start);
      if (pwm_hi && pwm_lo) ov_c++;
    end
  endtask

  initial begin
    int raw_c, hi_c, lo_c, ps_c, ov_c, mism, acc;

    n_tests  = 0;
    n_fail   = 0;
    ov_total = 0;
    cnt      = '0;

    //          duty    dt   raw  hi   lo
    vecs[0] = '{8'd0,   4'd3,   0,   0, 128};
    vecs[1] = '{8'd1,   4'd0,   1,   1, 127};
    vecs[2] = '{8'd32,  4'd0,  32,  32,  96};
    vecs[3] = '{8'd64,  4'd3,  64,  61,  61};
    vecs[4] = '{8'd64,  4'd0,  64,  64,  64};
    vecs[5] = '{8'd127, 4'd3, 127, 127,   0};
    vecs[6] = '{8'd127, 4'd0, 127, 127,   1};
    vecs[7] = '{8'd128, 4'd2, 128, 128,   0};
    vecs[8] = '{8'd200, 4'd2, 128, 128,   0};
    vecs[9] = '{8'd2,   4'd5,   2,   0, 126};

    reset       = 1'b1;
    count_en    = 1'b1;
    out_en      = 1'b1;
    duty_in     = '0;
    duty_wr     = 1'b0;
    deadtime_in = 4'd1;
    counter_in  = '0;

    // Reset: all outputs low while held.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_outs_%0d", i),
            int'({pwm_raw, pwm_hi, pwm_lo, period_start, duty_pending}), 0);
    end

    // Release with zero duty: one dead-time cycle, then low side on.
    reset = 1'b0;
    tick();
    check("rel_e1_drives", int'({pwm_hi, pwm_lo}), 0);
    check("rel_e1_ps", int'(period_start), 1);
    tick();
    check("rel_e2_lo", int'(pwm_lo), 1);
    check("rel_e2_hi", int'(pwm_hi), 0);
    check("rel_e2_raw", int'(pwm_raw), 0);

    // Shadowed update written mid-period.
    run_to(10);
    write_duty(8'd32);
    check("shadow_pending", int'(duty_pending), 1);
    acc = 0;
    for (int n = 0; n < 300 && counter_in != 7'd127; n++) begin
      tick();
      acc += int'(pwm_raw);
    end
    check("shadow_at127", int'(counter_in), 127);
    check("shadow_raw_before_wrap", acc, 0);
    check("shadow_pend_at127", int'(duty_pending), 1);
    tick();
    check("shadow_pend_cleared", int'(duty_pending), 0);
    check("shadow_raw_last_old", int'(pwm_raw), 0);
    tick();
    check("shadow_ps_at0", int'(period_start), 1);
    mism = 0;
    for (int i = 0; i < 128; i++) begin
      if (pwm_raw != (i < 32)) mism++;
      tick();
    end
    check("shadow_window", mism, 0);

    // Table-driven steady-state periods.
    for (int v = 0; v < 10; v++) begin
      deadtime_in = vecs[v].dt;
      write_duty(vecs[v].duty);
      check($sformatf("vec%0d_pend", v), int'(duty_pending), 1);
      wait_pend_clear();
      for (int i = 0; i < 128; i++) tick();
      measure(raw_c, hi_c, lo_c, ps_c, ov_c);
      check($sformatf("vec%0d_raw", v), raw_c, vecs[v].exp_raw);
      check($sformatf("vec%0d_hi", v), hi_c, vecs[v].exp_hi);
      check($sformatf("vec%0d_lo", v), lo_c, vecs[v].exp_lo);
      check($sformatf("vec%0d_ps", v), ps_c, 1);
      check($sformatf("vec%0d_overlap", v), ov_c, 0);
    end

    // Write coincident with the transfer edge.
    deadtime_in = 4'd0;
    run_to(50);
    write_duty(8'd10);
    run_to(127);
    duty_in = 8'd20;
    duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    check("coinc_pending", int'(duty_pending), 1);
    measure(raw_c, hi_c, lo_c, ps_c, ov_c);
    check("coinc_old_raw", raw_c, 10);
    check("coinc_pend_after", int'(duty_pending), 0);
    measure(raw_c, hi_c, lo_c, ps_c, ov_c);
    check("coinc_new_raw", raw_c, 20);

    // out_en dropped mid-period, then restored with dead time 3.
    deadtime_in = 4'd3;
    run_to(5);
    check("oe_pre_hi", int'(pwm_hi), 1);
    out_en = 1'b0;
    tick();
    check("oe_off_drives", int'({pwm_hi, pwm_lo}), 0);
    out_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("oe_restore_hi_%0d", i), int'(pwm_hi), (i == 4) ? 1 : 0);
      check($sformatf("oe_restore_lo_%0d", i), int'(pwm_lo), 0);
    end

    // Stalled counter: no repeated period_start pulses.
    run_to(0);
    count_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_ps_%0d", i), int'(period_start), 0);
    end
    count_en = 1'b1;
    tick();
    check("stall_resume_ps", int'(period_start), 1);
    tick();
    check("stall_resume_ps_drop", int'(period_start), 0);

    // Reset mid-period clears everything including the active duty.
    run_to(5);
    reset = 1'b1;
    tick();
    check("midreset_outs",
          int'({pwm_raw, pwm_hi, pwm_lo, period_start, duty_pending}), 0);
    reset = 1'b0;
    measure(raw_c, hi_c, lo_c, ps_c, ov_c);
    check("midreset_raw", raw_c, 0);
    check("midreset_hi", hi_c, 0);

    check("overlap_total", ov_total, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
